burst_ram_arbiter: RTL and testbench
====================================

Name: burst_ram_arbiter

Overview:
- Two-requester arbiter that shares one BurstRAM command/data port between the instruction cache (requester I) and the data cache (requester D).
- Sits between the two caches and BurstRAM inside the cache top level.
- Grants the port round-robin and routes all command and write-data signals from the granted requester.
- Gates read-valid back to the owner only, and holds the grant until the burst transaction is fully complete.

Parameters:
- RAM_DEPTH_BITWIDTH, 4: BurstRAM address width.
- RAM_BURST_DATA_BITWIDTH, 64: width of one burst beat.
- RAM_BURST_DATA_COUNT, 4: beats per read/write burst.

Ports:
- clk  in  1  clock; one clock domain, all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- i_req  in  1  I requests the port; held high until i_done.
- i_cmd  in  1  I command: 0 = read, 1 = write.
- i_cmd_en  in  1  I command strobe.
- i_addr  in  RAM_DEPTH_BITWIDTH  I burst address.
- i_wr_data  in  RAM_BURST_DATA_BITWIDTH  I write beat.
- i_data_mask  in  RAM_BURST_DATA_BITWIDTH/8  I byte mask.
- i_gnt  out  1  I owns the port.
- i_rd_data_valid  out  1  read beat valid for I.
- i_done  out  1  one-cycle pulse: I transaction complete.
- d_req, d_cmd, d_cmd_en, d_addr, d_wr_data, d_data_mask  in  as for I  D requester.
- d_gnt, d_rd_data_valid, d_done  out  1 each  as for I.
- br_cmd  out  1  to BurstRAM.
- br_cmd_en  out  1  to BurstRAM.
- br_addr  out  RAM_DEPTH_BITWIDTH  to BurstRAM.
- br_wr_data  out  RAM_BURST_DATA_BITWIDTH  to BurstRAM.
- br_data_mask  out  RAM_BURST_DATA_BITWIDTH/8  to BurstRAM.
- br_rd_data_valid  in  1  from BurstRAM.
- br_busy  in  1  from BurstRAM; high while a burst is in progress.
- (br_rd_data goes to both caches directly; it is not routed here.)

Behaviour:
- Reset values:
  - state = IDLE.
  - i_gnt = d_gnt = 0; i_done = d_done = 0.
  - br_cmd_en = 0.
  - last_owner = D, so I wins the first tie.
  - beat counter = 0.
- States: IDLE, GRANTED, SETTLE, WAIT_READ, WAIT_BUSY.
- IDLE:
  - Only i_req high → owner = I; only d_req high → owner = D.
  - Both high → owner = the requester that is not last_owner.
  - Go to GRANTED; x_gnt is registered and goes high the next cycle.
- GRANTED:
  - br_cmd, br_addr, br_wr_data and br_data_mask are combinationally muxed from the owner.
  - br_cmd_en = owner cmd_en && !br_busy.
  - On the first accepted cmd_en, latch cmd and go to SETTLE.
- SETTLE: exactly one cycle, so br_busy can rise. Then read → WAIT_READ, write → WAIT_BUSY.
- WAIT_READ:
  - Count br_rd_data_valid beats.
  - When count reaches RAM_BURST_DATA_COUNT, go to WAIT_BUSY.
- WAIT_BUSY:
  - When br_busy == 0: pulse owner x_done for one cycle, drop x_gnt, set last_owner = owner, go to IDLE.
- Fixed costs:
  - Minimum grant latency from req to gnt: 1 cycle.
  - Turnaround between transactions: 1 cycle in IDLE.
- One transaction per grant:
  - Later cmd_en from the owner is masked until re-grant.
  - cmd_en from the non-owner is always masked.
- Requester signals must be ignored in any state where they are not the owner's.
- Mux outputs are all-zero whenever no grant is active.
- Writes: the owner drives beat 0 in the cmd_en cycle and later beats on following cycles; the mux stays on the owner through WAIT_BUSY.
- br_rd_data_valid:
  - Routed to x_rd_data_valid of the owner only, in WAIT_READ and WAIT_BUSY.
  - The other requester's valid is held 0.
  - Valid pulses outside a read transaction are dropped.
- Beat counter:
  - Width $clog2(RAM_BURST_DATA_COUNT+1).
  - Cleared on entry to SETTLE; never wraps.
  - Extra beats after the count is reached are ignored.
- Requester drops req before issuing cmd_en (in GRANTED): release with no x_done, no change to last_owner, back to IDLE.
- req drop after cmd_en is ignored; the transaction runs to completion.
- Simultaneous new requests during an active transaction wait. Fairness is strict alternation under continuous contention.
- rst asserted mid-transaction: return to reset values next cycle; no x_done is issued.

Decomposition:
- Shared cache package holds:
  - State encoding (one-hot, 5 bits).
  - Command constants CMD_READ = 0 and CMD_WRITE = 1, reused by the caches.
  - Owner encoding (OWNER_I = 0, OWNER_D = 1).
- One natural sub-module: burst_ram_arbiter_rr, a 2-way round-robin picker (req_i, req_d, last_owner → owner, valid), purely combinational.

Test Plan:
- Reset, then i_req=1 for a read at addr 4'h3 with 4 valid beats:
  - i_gnt rises 1 cycle after req.
  - br_addr = 3 when br_cmd_en is asserted.
  - i_rd_data_valid is high for exactly 4 cycles; d_rd_data_valid stays 0.
  - i_done pulses once after br_busy falls.
- i_req and d_req rise in the same cycle after reset:
  - I is granted first, then D.
  - With both held continuously: sequence I, D, I, D.
- D write, mask 8'h0F, data 64'hA5 on beats 0–3:
  - br_wr_data and br_data_mask follow d_*.
  - i_cmd_en pulsed mid-write gives br_cmd_en = 0.
  - d_done pulses once br_busy = 0.
- Owner pulses cmd_en twice:
  - Only the first reaches br_cmd_en.
  - Stray br_rd_data_valid in IDLE produces no i/d valid.
- rst asserted during WAIT_READ after 2 beats:
  - Next cycle: gnts = 0, br_cmd_en = 0, no done pulse.
  - Next contention goes to I.
- i_req dropped in GRANTED before cmd_en:
  - Back to IDLE, no i_done.
  - A pending d_req is granted the following cycle.

Source files
------------

// File: rtl/burst_ram_arbiter_pkg.sv
// Shared cache package: arbiter state encoding, BurstRAM command constants
// (also used by the caches) and requester owner encoding.
package burst_ram_arbiter_pkg;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_GRANTED   = 5'b00010,
    ST_SETTLE    = 5'b00100,
    ST_WAIT_READ = 5'b01000,
    ST_WAIT_BUSY = 5'b10000
  } arb_state_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

endpackage

// File: rtl/burst_ram_arbiter_rr.sv
// 2-way round-robin picker.
//   req_i, req_d : pending requests from the I and D caches
//   last_owner   : requester that completed the most recent transaction
//   owner        : selected requester (meaningful when valid)
//   valid        : at least one request pending
// Purely combinational; on a tie the requester that is not last_owner wins.
module burst_ram_arbiter_rr
  import burst_ram_arbiter_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last_owner,
  output owner_t owner,
  output logic   valid
);

  always_comb begin
    valid = req_i | req_d;
    owner = OWNER_I;
    if (req_i && req_d) begin
      owner = (last_owner == OWNER_I) ? OWNER_D : OWNER_I;
    end else if (req_d) begin
      owner = OWNER_D;
    end
  end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Arbiter sharing one BurstRAM command/data port between the instruction
// cache (I) and the data cache (D).
//   clk, rst               : clock, synchronous active-high reset
//   i_* / d_* inputs       : per-requester req, cmd, cmd_en, addr, wr_data, mask
//   i_gnt / d_gnt          : requester owns the port
//   i_rd_data_valid / d_.. : read beat valid, routed to the owner only
//   i_done / d_done        : one-cycle pulse when the owner's transaction ends
//   br_* outputs           : command/write-data mux toward BurstRAM
//   br_rd_data_valid, br_busy : status from BurstRAM
// One transaction per grant; the grant is held until BurstRAM is idle again.
module burst_ram_arbiter
  import burst_ram_arbiter_pkg::*;
#(
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int RAM_BURST_DATA_COUNT    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,

  input  logic                                 i_req,
  input  logic                                 i_cmd,
  input  logic                                 i_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        i_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   i_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] i_data_mask,
  output logic                                 i_gnt,
  output logic                                 i_rd_data_valid,
  output logic                                 i_done,

  input  logic                                 d_req,
  input  logic                                 d_cmd,
  input  logic                                 d_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        d_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   d_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] d_data_mask,
  output logic                                 d_gnt,
  output logic                                 d_rd_data_valid,
  output logic                                 d_done,

  output logic                                 br_cmd,
  output logic                                 br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic                                 br_rd_data_valid,
  input  logic                                 br_busy
);

  localparam int CNT_W = $clog2(RAM_BURST_DATA_COUNT + 1);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(RAM_BURST_DATA_COUNT);

  arb_state_t       state_q, state_d;
  owner_t           owner_q, owner_d;
  owner_t           last_owner_q, last_owner_d;
  logic             cmd_q, cmd_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

  owner_t rr_owner;
  logic   rr_valid;

  logic active;
  logic owner_req;
  logic owner_cmd;
  logic owner_cmd_en;
  logic cmd_accept;
  logic rd_route;
  logic finish;

  burst_ram_arbiter_rr u_rr (
    .req_i      (i_req),
    .req_d      (d_req),
    .last_owner (last_owner_q),
    .owner      (rr_owner),
    .valid      (rr_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWNER_I;
      last_owner_q <= OWNER_D;
      cmd_q        <= CMD_READ;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cmd_q        <= cmd_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Owner-side views of the requester inputs; the non-owner is never looked at
  // once a grant is active.
  always_comb begin
    active       = (state_q != ST_IDLE);
    owner_req    = (owner_q == OWNER_D) ? d_req    : i_req;
    owner_cmd    = (owner_q == OWNER_D) ? d_cmd    : i_cmd;
    owner_cmd_en = (owner_q == OWNER_D) ? d_cmd_en : i_cmd_en;
    cmd_accept   = (state_q == ST_GRANTED) && owner_cmd_en && !br_busy;
    // Valid beats are only meaningful while a read burst is outstanding.
    rd_route     = br_rd_data_valid &&
                   ((state_q == ST_WAIT_READ) ||
                    ((state_q == ST_WAIT_BUSY) && (cmd_q == CMD_READ)));
    finish       = (state_q == ST_WAIT_BUSY) && !br_busy;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    cmd_d        = cmd_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rr_valid) begin
          owner_d = rr_owner;
          state_d = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (cmd_accept) begin
          cmd_d      = owner_cmd;
          beat_cnt_d = '0;
          state_d    = ST_SETTLE;
        end else if (!owner_req) begin
          // Released before any command: nothing completed, fairness untouched.
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        state_d = (cmd_q == CMD_READ) ? ST_WAIT_READ : ST_WAIT_BUSY;
      end
      ST_WAIT_READ: begin
        if (br_rd_data_valid && (beat_cnt_q != BEAT_LAST)) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
        if (beat_cnt_d == BEAT_LAST) begin
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!br_busy) begin
          last_owner_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    br_cmd          = 1'b0;
    br_addr         = '0;
    br_wr_data      = '0;
    br_data_mask    = '0;
    br_cmd_en       = cmd_accept;
    i_gnt           = active && (owner_q == OWNER_I);
    d_gnt           = active && (owner_q == OWNER_D);
    i_rd_data_valid = rd_route && (owner_q == OWNER_I);
    d_rd_data_valid = rd_route && (owner_q == OWNER_D);
    i_done          = finish && (owner_q == OWNER_I);
    d_done          = finish && (owner_q == OWNER_D);
    if (active) begin
      if (owner_q == OWNER_D) begin
        br_cmd       = d_cmd;
        br_addr      = d_addr;
        br_wr_data   = d_wr_data;
        br_data_mask = d_data_mask;
      end else begin
        br_cmd       = i_cmd;
        br_addr      = i_addr;
        br_wr_data   = i_wr_data;
        br_data_mask = i_data_mask;
      end
    end
  end

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed self-checking bench for burst_ram_arbiter; BurstRAM status
// (br_busy, br_rd_data_valid) is driven by hand.
module tb_burst_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req, i_cmd, i_cmd_en;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wr_data;
  logic [MW-1:0] i_data_mask;
  logic          i_gnt, i_rd_data_valid, i_done;
  logic          d_req, d_cmd, d_cmd_en;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wr_data;
  logic [MW-1:0] d_data_mask;
  logic          d_gnt, d_rd_data_valid, d_done;
  logic          br_cmd, br_cmd_en;
  logic [AW-1:0] br_addr;
  logic [DW-1:0] br_wr_data;
  logic [MW-1:0] br_data_mask;
  logic          br_rd_data_valid, br_busy;

  int errors = 0;
  int checks = 0;

  burst_ram_arbiter #(
    .RAM_DEPTH_BITWIDTH      (AW),
    .RAM_BURST_DATA_BITWIDTH (DW),
    .RAM_BURST_DATA_COUNT    (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_req            (i_req),
    .i_cmd            (i_cmd),
    .i_cmd_en         (i_cmd_en),
    .i_addr           (i_addr),
    .i_wr_data        (i_wr_data),
    .i_data_mask      (i_data_mask),
    .i_gnt            (i_gnt),
    .i_rd_data_valid  (i_rd_data_valid),
    .i_done           (i_done),
    .d_req            (d_req),
    .d_cmd            (d_cmd),
    .d_cmd_en         (d_cmd_en),
    .d_addr           (d_addr),
    .d_wr_data        (d_wr_data),
    .d_data_mask      (d_data_mask),
    .d_gnt            (d_gnt),
    .d_rd_data_valid  (d_rd_data_valid),
    .d_done           (d_done),
    .br_cmd           (br_cmd),
    .br_cmd_en        (br_cmd_en),
    .br_addr          (br_addr),
    .br_wr_data       (br_wr_data),
    .br_data_mask     (br_data_mask),
    .br_rd_data_valid (br_rd_data_valid),
    .br_busy          (br_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  // Runs one write transaction from GRANTED through to the following IDLE
  // cycle, br_busy held low. drop releases the owner's req on its done cycle.
  task automatic txn_write(input logic is_d, input logic drop);
    if (is_d) begin d_cmd = 1'b1; d_cmd_en = 1'b1; end
    else      begin i_cmd = 1'b1; i_cmd_en = 1'b1; end
    settle;
    chk("txn_gnt_i", 64'(i_gnt), 64'(!is_d));
    chk("txn_gnt_d", 64'(d_gnt), 64'(is_d));
    chk("txn_cmd_en", 64'(br_cmd_en), 1);
    tick;
    i_cmd_en = 1'b0;
    d_cmd_en = 1'b0;
    tick;
    settle;
    chk("txn_done_i", 64'(i_done), 64'(!is_d));
    chk("txn_done_d", 64'(d_done), 64'(is_d));
    if (drop) begin
      if (is_d) d_req = 1'b0; else i_req = 1'b0;
    end
    tick;
    settle;
    chk("txn_idle_gnt", 64'({i_gnt, d_gnt}), 0);
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; i_cmd = 0; i_cmd_en = 0; i_addr = '0; i_wr_data = '0; i_data_mask = '0;
    d_req = 0; d_cmd = 0; d_cmd_en = 0; d_addr = '0; d_wr_data = '0; d_data_mask = '0;
    br_rd_data_valid = 0; br_busy = 0;
    tick;
    tick;
    rst = 1'b0;
    settle;
    chk("rst_gnt", 64'({i_gnt, d_gnt}), 0);
    chk("rst_done", 64'({i_done, d_done}), 0);
    chk("rst_cmd_en", 64'(br_cmd_en), 0);
    chk("rst_addr", 64'(br_addr), 0);

    // I read at address 3, four beats.
    i_req = 1'b1;
    settle;
    chk("rd_gnt_before", 64'(i_gnt), 0);
    tick;
    i_cmd = 1'b0; i_cmd_en = 1'b1; i_addr = 4'h3;
    settle;
    chk("rd_gnt_after", 64'(i_gnt), 1);
    chk("rd_cmd_en", 64'(br_cmd_en), 1);
    chk("rd_addr", 64'(br_addr), 3);
    tick;
    i_cmd_en = 1'b0; br_busy = 1'b1;
    tick;
    for (int k = 0; k < 4; k++) begin
      br_rd_data_valid = 1'b1;
      settle;
      chk("rd_i_valid", 64'(i_rd_data_valid), 1);
      chk("rd_d_valid", 64'(d_rd_data_valid), 0);
      tick;
    end
    br_rd_data_valid = 1'b0;
    settle;
    chk("rd_valid_end", 64'(i_rd_data_valid), 0);
    chk("rd_done_busy", 64'(i_done), 0);
    tick;
    br_busy = 1'b0;
    settle;
    chk("rd_done", 64'(i_done), 1);
    chk("rd_d_done", 64'(d_done), 0);
    i_req = 1'b0;
    tick;
    settle;
    chk("rd_done_once", 64'(i_done), 0);
    chk("rd_gnt_drop", 64'(i_gnt), 0);

    // Continuous contention after reset: I, D, I, D.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    tick;
    txn_write(1'b0, 1'b0);
    tick;
    txn_write(1'b1, 1'b0);
    tick;
    txn_write(1'b0, 1'b0);
    tick;
    txn_write(1'b1, 1'b0);
    i_req = 1'b0; d_req = 1'b0;
    tick;

    // D write with mask 0F; non-owner inputs and cmd_en are ignored.
    d_req = 1'b1;
    tick;
    d_cmd = 1'b1; d_cmd_en = 1'b1; d_addr = 4'h5;
    d_wr_data = 64'hA5; d_data_mask = 8'h0F;
    i_addr = 4'hC; i_wr_data = 64'hFF; i_data_mask = 8'hF0;
    settle;
    chk("wr_cmd_en", 64'(br_cmd_en), 1);
    chk("wr_cmd", 64'(br_cmd), 1);
    chk("wr_addr", 64'(br_addr), 5);
    chk("wr_data0", br_wr_data, 64'hA5);
    chk("wr_mask0", 64'(br_data_mask), 8'h0F);
    tick;
    d_cmd_en = 1'b0; i_cmd_en = 1'b1; br_busy = 1'b1;
    settle;
    chk("wr_i_cmd_en_masked", 64'(br_cmd_en), 0);
    chk("wr_data1", br_wr_data, 64'hA5);
    chk("wr_i_gnt", 64'(i_gnt), 0);
    tick;
    i_cmd_en = 1'b0; br_rd_data_valid = 1'b1;
    settle;
    chk("wr_stray_valid", 64'({i_rd_data_valid, d_rd_data_valid}), 0);
    chk("wr_mask2", 64'(br_data_mask), 8'h0F);
    chk("wr_data2", br_wr_data, 64'hA5);
    chk("wr_done_busy", 64'(d_done), 0);
    tick;
    br_rd_data_valid = 1'b0; br_busy = 1'b0;
    settle;
    chk("wr_done", 64'(d_done), 1);
    chk("wr_i_done", 64'(i_done), 0);
    d_req = 1'b0;
    tick;
    settle;
    chk("wr_done_once", 64'(d_done), 0);
    chk("idle_mux_data", br_wr_data, 0);
    chk("idle_mux_mask", 64'(br_data_mask), 0);
    chk("wr_gnt_drop", 64'(d_gnt), 0);

    // Owner pulses cmd_en twice: only the first is passed on.
    d_req = 1'b1;
    tick;
    d_cmd = 1'b0; d_cmd_en = 1'b1; d_addr = 4'h7;
    settle;
    chk("dbl_first", 64'(br_cmd_en), 1);
    tick;
    settle;
    chk("dbl_second_settle", 64'(br_cmd_en), 0);
    tick;
    br_busy = 1'b1;
    settle;
    chk("dbl_second_read", 64'(br_cmd_en), 0);
    d_cmd_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      br_rd_data_valid = 1'b1;
      settle;
      chk("dbl_d_valid", 64'(d_rd_data_valid), 1);
      chk("dbl_i_valid", 64'(i_rd_data_valid), 0);
      tick;
    end
    br_rd_data_valid = 1'b0; br_busy = 1'b0;
    settle;
    chk("dbl_done", 64'(d_done), 1);
    d_req = 1'b0;
    tick;
    br_rd_data_valid = 1'b1;
    settle;
    chk("idle_stray_valid", 64'({i_rd_data_valid, d_rd_data_valid}), 0);
    br_rd_data_valid = 1'b0;

    // I completes a write so last_owner = I, then D read is reset mid-burst.
    i_req = 1'b1;
    tick;
    txn_write(1'b0, 1'b1);
    d_req = 1'b1;
    tick;
    d_cmd = 1'b0; d_cmd_en = 1'b1;
    tick;
    d_cmd_en = 1'b0; br_busy = 1'b1;
    tick;
    br_rd_data_valid = 1'b1;
    tick;
    tick;
    br_rd_data_valid = 1'b0;
    settle;
    chk("pre_reset_gnt", 64'(d_gnt), 1);
    rst = 1'b1;
    tick;
    rst = 1'b0; br_busy = 1'b0; i_req = 1'b1;
    settle;
    chk("mid_rst_gnt", 64'({i_gnt, d_gnt}), 0);
    chk("mid_rst_cmd_en", 64'(br_cmd_en), 0);
    chk("mid_rst_done", 64'({i_done, d_done}), 0);
    tick;
    settle;
    chk("post_rst_i_wins", 64'(i_gnt), 1);
    chk("post_rst_d_waits", 64'(d_gnt), 0);

    // I releases in GRANTED before cmd_en; pending D follows.
    i_req = 1'b0;
    settle;
    chk("rel_gnt_hold", 64'(i_gnt), 1);
    tick;
    settle;
    chk("rel_gnt_drop", 64'(i_gnt), 0);
    chk("rel_no_done", 64'(i_done), 0);
    tick;
    settle;
    chk("rel_d_granted", 64'(d_gnt), 1);
    d_req = 1'b0;
    tick;
    settle;
    chk("rel_d_release", 64'(d_done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
